// File: rtl/register_file_32x32_pkg.sv
// Shared constants and helpers for the 32x32 register file.
package register_file_32x32_pkg;

  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int DATA_W_DEFAULT = 32;
  localparam int ZERO_IDX       = 0;

  // True when the given index is the hardwired-zero register for this configuration.
  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] idx, input int zero_reg);
    return (zero_reg != 0) && (idx == REG_ADDR_W'(ZERO_IDX));
  endfunction

endpackage

// File: rtl/one_thirty_two_demux.sv
// 1-to-32 demultiplexer: turns an enable and a 5-bit index into a one-hot vector.
module one_thirty_two_demux
  import register_file_32x32_pkg::*;
(
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] sel,
  output logic [REG_COUNT-1:0]  out
);

  logic [REG_COUNT-1:0] w_onehot;

  // Decode the index into a single set bit; disabled yields all zeros.
  always_comb begin
    w_onehot = '0;
    if (en) begin
      w_onehot[sel] = 1'b1;
    end
  end

  assign out = w_onehot;

endmodule

// File: rtl/register_32.sv
// Single storage register with synchronous active-low clear and load enable.
module register_32
  import register_file_32x32_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_q;

  // Clear has priority over load; otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/register_file_32x32.sv
// 32-entry register file: one synchronous write port, two combinational read ports.
// Reads see the stored value only; there is no write-through bypass.
module register_file_32x32
  import register_file_32x32_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrEn,
  input  logic [REG_ADDR_W-1:0] wrReg,
  input  logic [DATA_W-1:0]     wrData,
  input  logic [REG_ADDR_W-1:0] rdRegA,
  input  logic [REG_ADDR_W-1:0] rdRegB,
  output logic [DATA_W-1:0]     rdDataA,
  output logic [DATA_W-1:0]     rdDataB
);

  logic [REG_COUNT-1:0] w_wr_onehot;
  logic [REG_COUNT-1:0] w_load;
  logic [DATA_W-1:0]    w_q [REG_COUNT];

  one_thirty_two_demux u_demux (
    .en  (wrEn),
    .sel (wrReg),
    .out (w_wr_onehot)
  );

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    // The hardwired-zero entry never sees a load, so it stays at its cleared value.
    localparam bit IS_ZERO = (ZERO_REG != 0) && (i == ZERO_IDX);
    assign w_load[i] = w_wr_onehot[i] & ~IS_ZERO;

    register_32 #(.DATA_W(DATA_W)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_load[i]),
      .d     (wrData),
      .q     (w_q[i])
    );
  end

  // Read port A: forced to zero for the hardwired-zero index.
  always_comb begin
    rdDataA = w_q[rdRegA];
    if (is_zero_reg(rdRegA, ZERO_REG)) begin
      rdDataA = '0;
    end
  end

  // Read port B: same selection as port A, independent index.
  always_comb begin
    rdDataB = w_q[rdRegB];
    if (is_zero_reg(rdRegB, ZERO_REG)) begin
      rdDataB = '0;
    end
  end

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed, table-driven bench for register_file_32x32 (one instance per ZERO_REG setting).
module tb_register_file_32x32;

  logic        clk;
  logic        rst_n;
  logic        wrEn;
  logic [4:0]  wrReg;
  logic [31:0] wrData;
  logic [4:0]  rdRegA;
  logic [4:0]  rdRegB;
  logic [31:0] z_rdDataA, z_rdDataB;
  logic [31:0] n_rdDataA, n_rdDataB;

  int n_total = 0;
  int n_pass  = 0;

  register_file_32x32 #(.DATA_W(32), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wrEn(wrEn), .wrReg(wrReg), .wrData(wrData),
    .rdRegA(rdRegA), .rdRegB(rdRegB), .rdDataA(z_rdDataA), .rdDataB(z_rdDataB)
  );

  register_file_32x32 #(.DATA_W(32), .ZERO_REG(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .wrEn(wrEn), .wrReg(wrReg), .wrData(wrData),
    .rdRegA(rdRegA), .rdRegB(rdRegB), .rdDataA(n_rdDataA), .rdDataB(n_rdDataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [4:0]  ra;
    logic [4:0]  rb;
    bit          chk_pre;
    logic [31:0] pre_a;
    logic [31:0] pre_b;
    logic [31:0] post_a;
    logic [31:0] post_b;
    logic [31:0] post_na;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wrEn = 1'b0; wrReg = '0; wrData = '0; rdRegA = '0; rdRegB = '0;

    //        rst we reg  data           ra  rb  pre  preA          preB          postA         postB         postNA
    vecs[0]  = '{0, 1,  7, 32'hDEADBEEF,  7,  7, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{0, 1,  7, 32'hDEADBEEF,  7,  7, 1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1, 1,  5, 32'h12345678,  5,  4, 1, 32'h0,        32'h0,        32'h12345678, 32'h0,        32'h12345678};
    vecs[3]  = '{1, 0,  5, 32'hFFFFFFFF,  5,  5, 1, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[4]  = '{1, 0,  5, 32'hFFFFFFFF,  5,  5, 1, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[5]  = '{1, 0,  5, 32'hFFFFFFFF,  5,  5, 1, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    vecs[6]  = '{1, 1, 31, 32'hA5A5A5A5, 31,  5, 1, 32'h0,        32'h12345678, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};
    vecs[7]  = '{1, 1,  0, 32'h0000FFFF,  0,  0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0000FFFF};
    vecs[8]  = '{1, 1, 15, 32'h00000001, 15, 15, 1, 32'h0,        32'h0,        32'h1,        32'h1,        32'h1};
    vecs[9]  = '{1, 1, 15, 32'h00000002, 15, 15, 1, 32'h1,        32'h1,        32'h2,        32'h2,        32'h2};
    vecs[10] = '{1, 1,  9, 32'hCAFEF00D,  9, 10, 1, 32'h0,        32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
    vecs[11] = '{0, 1, 10, 32'h00000077,  9, 10, 1, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        32'h0};

    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      rst_n = vecs[v].rst_n; wrEn = vecs[v].we; wrReg = vecs[v].wr_reg;
      wrData = vecs[v].wr_data; rdRegA = vecs[v].ra; rdRegB = vecs[v].rb;
      #1;
      if (vecs[v].chk_pre) begin
        chk($sformatf("v%0d pre A", v), z_rdDataA, vecs[v].pre_a);
        chk($sformatf("v%0d pre B", v), z_rdDataB, vecs[v].pre_b);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d post A", v), z_rdDataA, vecs[v].post_a);
      chk($sformatf("v%0d post B", v), z_rdDataB, vecs[v].post_b);
      chk($sformatf("v%0d post A nz", v), n_rdDataA, vecs[v].post_na);

      // After the initial two reset edges, every index must read zero on both ports.
      if (v == 1) begin
        wrEn = 1'b0;
        for (int i = 0; i < 32; i++) begin
          rdRegA = 5'(i); rdRegB = 5'(31 - i); #1;
          chk($sformatf("rst sweep A%0d", i), z_rdDataA, 32'h0);
          chk($sformatf("rst sweep B%0d", 31 - i), z_rdDataB, 32'h0);
          chk($sformatf("rst sweep nz A%0d", i), n_rdDataA, 32'h0);
        end
      end
    end

    // Mid-operation reset cleared everything, including non-zero-hardwired reg 0.
    @(negedge clk);
    rst_n = 1'b1; wrEn = 1'b0;
    rdRegA = 5'd31; rdRegB = 5'd5; #1;
    chk("post-reset r31", z_rdDataA, 32'h0);
    chk("post-reset r5", z_rdDataB, 32'h0);
    rdRegA = 5'd0; rdRegB = 5'd15; #1;
    chk("post-reset nz r0", n_rdDataA, 32'h0);
    chk("post-reset r15", z_rdDataB, 32'h0);

    // Write reg 3, then pulse rst_n low only between edges: state must hold.
    wrEn = 1'b1; wrReg = 5'd3; wrData = 32'h3C3C3C3C; rdRegA = 5'd3; rdRegB = 5'd3;
    @(posedge clk); #1;
    wrEn = 1'b0;
    chk("write r3", z_rdDataA, 32'h3C3C3C3C);
    @(negedge clk);
    rst_n = 1'b0; #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("glitch rst hold A", z_rdDataA, 32'h3C3C3C3C);
    chk("glitch rst hold nz B", n_rdDataB, 32'h3C3C3C3C);

    // Write to reg 0 on the zero-hardwired instance must not disturb reg 3.
    @(negedge clk);
    wrEn = 1'b1; wrReg = 5'd0; wrData = 32'h11112222; rdRegA = 5'd0; rdRegB = 5'd3;
    @(posedge clk); #1;
    wrEn = 1'b0;
    chk("r0 write ignored", z_rdDataA, 32'h0);
    chk("r0 write nz", n_rdDataA, 32'h11112222);
    chk("r3 untouched", z_rdDataB, 32'h3C3C3C3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
